// File: rtl/alut_age_sweeper.sv
// rtl/alut_age_sweeper.sv - address-table age sweeper with prescaled timebase and lookup age check
// Sweeps the table invalidating aged / per-port / all entries and services lookup age checks between entries.
module alut_age_sweeper #(
  parameter int DEPTH_LOG2 = 8,
  parameter int TIME_W     = 32,
  parameter int MAC_W      = 48,
  parameter int PORT_W     = 2,
  parameter int CNT_W      = 16,
  localparam int EW        = 1 + TIME_W + PORT_W + MAC_W
) (
  input  logic                  pclk,
  input  logic                  p_reset,
  input  logic [1:0]            command,
  input  logic [PORT_W-1:0]     cmd_port,
  input  logic [7:0]            div_clk,
  input  logic [TIME_W-1:0]     best_bfr_age,
  input  logic                  check_age,
  input  logic [TIME_W-1:0]     last_accessed,
  input  logic [EW-1:0]         mem_rdata,
  output logic [TIME_W-1:0]     curr_time,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [EW-1:0]         mem_wdata,
  output logic [MAC_W-1:0]      lst_inv_addr,
  output logic [PORT_W-1:0]     lst_inv_port,
  output logic [CNT_W-1:0]      inval_cnt,
  output logic                  age_confirmed,
  output logic                  age_ok,
  output logic                  inval_in_prog,
  output logic                  sweep_done,
  output logic                  age_check_active
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CLR_CNT = (DEPTH_LOG2 >= CNT_W) ? {CNT_W{1'b1}} : CNT_W'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EVAL, S_WR, S_CLR, S_CHK} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [7:0]            r_clk_div_cnt;
  logic [TIME_W-1:0]     r_curr_time;
  logic [DEPTH_LOG2-1:0] r_mem_addr;
  logic [1:0]            r_mode;
  logic [PORT_W-1:0]     r_cmd_port;
  logic [MAC_W-1:0]      r_hold_mac;
  logic [PORT_W-1:0]     r_hold_port;
  logic [MAC_W-1:0]      r_lst_inv_addr;
  logic [PORT_W-1:0]     r_lst_inv_port;
  logic [CNT_W-1:0]      r_inval_cnt;
  logic                  r_age_confirmed;
  logic                  r_age_ok;
  logic                  r_inval_in_prog;
  logic                  r_sweep_done;
  logic                  r_resume;

  logic                  w_chk_req;
  logic                  w_rd_valid;
  logic [TIME_W-1:0]     w_rd_time;
  logic [PORT_W-1:0]     w_rd_port;
  logic [MAC_W-1:0]      w_rd_mac;
  logic [TIME_W-1:0]     w_rd_age;
  logic [TIME_W-1:0]     w_lk_age;
  logic                  w_hit;
  logic                  w_last;
  logic                  w_step;
  state_t                w_step_state;

  // A requester holds check_age until it sees the strobe; masking avoids a second check on that edge.
  assign w_chk_req  = check_age & ~r_age_confirmed;
  assign w_rd_valid = mem_rdata[EW-1];
  assign w_rd_time  = mem_rdata[EW-2 -: TIME_W];
  assign w_rd_port  = mem_rdata[MAC_W +: PORT_W];
  assign w_rd_mac   = mem_rdata[MAC_W-1:0];
  assign w_rd_age   = r_curr_time - w_rd_time;
  assign w_lk_age   = r_curr_time - last_accessed;
  assign w_hit      = w_rd_valid && ((r_mode == 2'b10 && w_rd_age >= best_bfr_age) ||
                                     (r_mode == 2'b01 && w_rd_port == r_cmd_port));
  assign w_last     = &r_mem_addr;
  assign w_step     = (r_state == S_EVAL && !w_hit) || (r_state == S_WR);
  assign w_step_state = w_last ? S_IDLE : (w_chk_req ? S_CHK : S_RD);

  always_ff @(posedge pclk) begin
    if (p_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_chk_req)               w_next_state = S_CHK;
        else if (command == 2'b11)   w_next_state = S_CLR;
        else if (command != 2'b00)   w_next_state = S_RD;
      end
      S_RD:    w_next_state = S_EVAL;
      S_EVAL:  w_next_state = w_hit ? S_WR : w_step_state;
      S_WR:    w_next_state = w_step_state;
      S_CLR:   w_next_state = w_last ? S_IDLE : S_CLR;
      S_CHK:   w_next_state = r_resume ? S_RD : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      r_clk_div_cnt   <= '0;
      r_curr_time     <= '0;
      r_mem_addr      <= '0;
      r_mode          <= '0;
      r_cmd_port      <= '0;
      r_hold_mac      <= '0;
      r_hold_port     <= '0;
      r_lst_inv_addr  <= '0;
      r_lst_inv_port  <= '0;
      r_inval_cnt     <= '0;
      r_age_confirmed <= 1'b0;
      r_age_ok        <= 1'b0;
      r_inval_in_prog <= 1'b0;
      r_sweep_done    <= 1'b0;
      r_resume        <= 1'b0;
    end else begin
      // Terminal compare uses >= so a lowered div_clk cannot strand the prescaler above it.
      if (r_clk_div_cnt >= div_clk) begin
        r_clk_div_cnt <= '0;
        r_curr_time   <= r_curr_time + 1'b1;
      end else begin
        r_clk_div_cnt <= r_clk_div_cnt + 1'b1;
      end

      r_sweep_done    <= 1'b0;
      r_age_confirmed <= 1'b0;

      if (w_next_state == S_CHK) r_resume <= (r_state != S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (!w_chk_req && command != 2'b00) begin
            r_mem_addr      <= '0;
            r_inval_cnt     <= '0;
            r_inval_in_prog <= 1'b0;
            r_mode          <= command;
            r_cmd_port      <= cmd_port;
          end
        end
        S_EVAL: begin
          r_hold_mac  <= w_rd_mac;
          r_hold_port <= w_rd_port;
        end
        S_WR: begin
          r_lst_inv_addr  <= r_hold_mac;
          r_lst_inv_port  <= r_hold_port;
          r_inval_in_prog <= 1'b1;
          if (r_inval_cnt != {CNT_W{1'b1}}) r_inval_cnt <= r_inval_cnt + 1'b1;
        end
        S_CLR: begin
          r_inval_in_prog <= 1'b1;
          if (w_last) begin
            r_sweep_done <= 1'b1;
            r_inval_cnt  <= CLR_CNT;
          end else begin
            r_mem_addr <= r_mem_addr + 1'b1;
          end
        end
        S_CHK: begin
          r_age_confirmed <= 1'b1;
          r_age_ok        <= (w_lk_age < best_bfr_age);
        end
        default: ;
      endcase

      if (w_step) begin
        if (w_last) r_sweep_done <= 1'b1;
        else        r_mem_addr   <= r_mem_addr + 1'b1;
      end
    end
  end

  assign curr_time        = r_curr_time;
  assign mem_addr         = r_mem_addr;
  assign mem_rd           = (r_state == S_RD);
  assign mem_wr           = (r_state == S_WR) || (r_state == S_CLR);
  assign mem_wdata        = '0;
  assign lst_inv_addr     = r_lst_inv_addr;
  assign lst_inv_port     = r_lst_inv_port;
  assign inval_cnt        = r_inval_cnt;
  assign age_confirmed    = r_age_confirmed;
  assign age_ok           = r_age_ok;
  assign inval_in_prog    = r_inval_in_prog;
  assign sweep_done       = r_sweep_done;
  assign age_check_active = (r_state != S_IDLE);

endmodule

// File: tb/tb_alut_age_sweeper.sv
// tb/tb_alut_age_sweeper.sv - self-checking bench for alut_age_sweeper
// Behavioural table model with per-entry invalidation rules and randomized sweeps / age checks.
module tb_alut_age_sweeper;
  localparam int DL2   = 2;
  localparam int TW    = 32;
  localparam int MW    = 48;
  localparam int PW    = 2;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << DL2;
  localparam int EW    = 1 + TW + PW + MW;

  logic           pclk = 1'b0;
  logic           p_reset = 1'b1;
  logic [1:0]     command = '0;
  logic [PW-1:0]  cmd_port = '0;
  logic [7:0]     div_clk = '0;
  logic [TW-1:0]  best_bfr_age = '0;
  logic           check_age = 1'b0;
  logic [TW-1:0]  last_accessed = '0;
  logic [EW-1:0]  mem_rdata = '0;
  logic [TW-1:0]  curr_time;
  logic [DL2-1:0] mem_addr;
  logic           mem_rd, mem_wr;
  logic [EW-1:0]  mem_wdata;
  logic [MW-1:0]  lst_inv_addr;
  logic [PW-1:0]  lst_inv_port;
  logic [CW-1:0]  inval_cnt;
  logic           age_confirmed, age_ok, inval_in_prog, sweep_done, age_check_active;

  alut_age_sweeper #(.DEPTH_LOG2(DL2), .TIME_W(TW), .MAC_W(MW), .PORT_W(PW), .CNT_W(CW)) dut (
    .pclk(pclk), .p_reset(p_reset), .command(command), .cmd_port(cmd_port), .div_clk(div_clk),
    .best_bfr_age(best_bfr_age), .check_age(check_age), .last_accessed(last_accessed),
    .mem_rdata(mem_rdata), .curr_time(curr_time), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .lst_inv_addr(lst_inv_addr), .lst_inv_port(lst_inv_port),
    .inval_cnt(inval_cnt), .age_confirmed(age_confirmed), .age_ok(age_ok),
    .inval_in_prog(inval_in_prog), .sweep_done(sweep_done), .age_check_active(age_check_active)
  );

  always #5 pclk = ~pclk;

  int            n_assert = 0;
  int            n_fail = 0;
  int            both_hi = 0;
  logic [EW-1:0] mem [DEPTH];
  int            wlog[$];
  int            rlog[$];
  logic [TW-1:0] t_now;
  logic [MW-1:0] exp_lst_mac;
  logic [PW-1:0] exp_lst_port;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic v, input logic [TW-1:0] ts,
                                       input logic [PW-1:0] p, input logic [MW-1:0] m);
    return {v, ts, p, m};
  endfunction

  // One clock: memory reacts to the strobes seen during the cycle, read data lands after the edge.
  task automatic tick();
    logic rd, wr;
    logic [DL2-1:0] a;
    rd = mem_rd; wr = mem_wr; a = mem_addr;
    if (rd === 1'b1 && wr === 1'b1) both_hi++;
    @(posedge pclk);
    #1;
    mem_rdata = (rd === 1'b1) ? mem[a] : EW'({$urandom, $urandom, $urandom});
    if (rd === 1'b1) rlog.push_back(int'(a));
    if (wr === 1'b1) begin
      mem[a] = '0;
      wlog.push_back(int'(a));
    end
    @(negedge pclk);
  endtask

  task automatic do_reset();
    p_reset = 1'b1;
    tick();
    tick();
    p_reset = 1'b0;
    exp_lst_mac = '0;
    exp_lst_port = '0;
  endtask

  // Time advances once per cycle with div_clk=0, then freezes for 256 cycles at div_clk=255.
  task automatic set_time(input int t);
    div_clk = 8'd0;
    do_reset();
    repeat (t) tick();
    chk("time_setup", curr_time, TW'(t));
    div_clk = 8'd255;
    t_now = TW'(t);
  endtask

  task automatic age_check(input string tag, input logic [TW-1:0] la, input logic [TW-1:0] bba,
                           input logic exp_ok);
    best_bfr_age = bba;
    last_accessed = la;
    check_age = 1'b1;
    tick();
    chk({tag, "_ack_early"}, age_confirmed, 1'b0);
    chk({tag, "_active"}, age_check_active, 1'b1);
    tick();
    chk({tag, "_ack"}, age_confirmed, 1'b1);
    chk({tag, "_age_ok"}, age_ok, exp_ok);
    check_age = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, age_confirmed, 1'b0);
  endtask

  task automatic run_sweep(input string tag, input logic [1:0] cmd, input logic [PW-1:0] port,
                           input logic do_chk, input logic [TW-1:0] la);
    int exp_w[$];
    int exp_r[$];
    int n = 0;
    int lat, c, chk_at;
    logic chk_seen;
    logic exp_ok, hit;
    logic [TW-1:0] age;
    logic [EW-1:0] e;
    logic [MW-1:0] lm;
    logic [PW-1:0] lp;
    lm = exp_lst_mac;
    lp = exp_lst_port;
    for (int i = 0; i < DEPTH; i++) begin
      e = mem[i];
      if (cmd == 2'b11) begin
        exp_w.push_back(i);
      end else begin
        exp_r.push_back(i);
        age = t_now - e[EW-2 -: TW];
        hit = e[EW-1] && ((cmd == 2'b10) ? (age >= best_bfr_age) : (e[MW +: PW] == port));
        if (hit) begin
          exp_w.push_back(i);
          n++;
          lm = e[MW-1:0];
          lp = e[MW +: PW];
        end
      end
    end
    if (cmd == 2'b11) n = DEPTH;
    lat = (cmd == 2'b11) ? DEPTH : 2 * DEPTH + n + (do_chk ? 1 : 0);
    exp_ok = (t_now - la) < best_bfr_age;
    wlog.delete();
    rlog.delete();
    c = 0;
    chk_at = -1;
    chk_seen = 1'b0;
    command = cmd;
    cmd_port = port;
    tick();
    chk({tag, "_prog_clear"}, inval_in_prog, 1'b0);
    chk({tag, "_active"}, age_check_active, 1'b1);
    while (sweep_done !== 1'b1 && c < 64) begin
      command = (c + 3 < lat) ? 2'($urandom) : 2'b00;
      cmd_port = PW'($urandom);
      if (do_chk && c == 2) begin
        last_accessed = la;
        check_age = 1'b1;
        chk_at = c;
      end
      tick();
      c++;
      if (check_age && age_confirmed === 1'b1) begin
        chk({tag, "_mid_age_ok"}, age_ok, exp_ok);
        chk({tag, "_mid_latency"}, (c - chk_at) <= 4, 1'b1);
        check_age = 1'b0;
        chk_seen = 1'b1;
      end
    end
    command = 2'b00;
    check_age = 1'b0;
    chk({tag, "_latency"}, c, lat);
    if (do_chk) chk({tag, "_chk_served"}, chk_seen, 1'b1);
    chk({tag, "_n_writes"}, wlog.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++) chk({tag, "_wr_addr"}, wlog[i], exp_w[i]);
    chk({tag, "_n_reads"}, rlog.size(), exp_r.size());
    for (int i = 0; i < exp_r.size() && i < rlog.size(); i++) chk({tag, "_rd_addr"}, rlog[i], exp_r[i]);
    chk({tag, "_inval_cnt"}, inval_cnt, CW'(n));
    chk({tag, "_lst_mac"}, lst_inv_addr, lm);
    chk({tag, "_lst_port"}, lst_inv_port, lp);
    if (cmd != 2'b11) chk({tag, "_in_prog"}, inval_in_prog, n > 0);
    tick();
    chk({tag, "_done_pulse"}, sweep_done, 1'b0);
    chk({tag, "_idle"}, age_check_active, 1'b0);
    exp_lst_mac = lm;
    exp_lst_port = lp;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] t, la;
    logic [1:0] cmd;
    int ws;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(negedge pclk);

    div_clk = 8'd3;
    do_reset();
    chk("rst_time", curr_time, '0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_rd", mem_rd, 1'b0);
    chk("rst_wr", mem_wr, 1'b0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_lst_mac", lst_inv_addr, '0);
    chk("rst_lst_port", lst_inv_port, '0);
    chk("rst_cnt", inval_cnt, '0);
    chk("rst_ack", age_confirmed, 1'b0);
    chk("rst_ok", age_ok, 1'b0);
    chk("rst_prog", inval_in_prog, 1'b0);
    chk("rst_done", sweep_done, 1'b0);
    chk("rst_active", age_check_active, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("prescale_time", curr_time, TW'(i / 4));
    end
    chk("time_after_20", curr_time, TW'(5));

    set_time(2);
    age_check("wrap_age", 32'hFFFF_FFFE, 32'd5, 1'b1);
    age_check("age_eq_limit", 32'hFFFF_FFFB, 32'd7, 1'b0);
    age_check("age_below_limit", 32'hFFFF_FFFB, 32'd8, 1'b1);
    age_check("limit_zero", 32'd2, 32'd0, 1'b0);

    set_time(100);
    best_bfr_age = 32'd10;
    mem[0] = mk(1'b1, 32'd95, 2'd1, 48'h0000_0000_00A0);
    mem[1] = mk(1'b1, 32'd80, 2'd2, 48'h1111_2222_3333);
    mem[2] = mk(1'b0, 32'd0, 2'd3, 48'h4444_5555_6666);
    mem[3] = mk(1'b1, 32'hFFFF_FFF0, 2'd3, 48'hAAAA_BBBB_CCCC);
    run_sweep("aged", 2'b10, 2'd0, 1'b0, '0);
    chk("aged_cnt_two", inval_cnt, CW'(2));
    chk("aged_lst_entry3", lst_inv_addr, 48'hAAAA_BBBB_CCCC);

    for (int i = 0; i < DEPTH; i++) mem[i] = mk(1'b1, t_now, PW'(i), MW'(i + 7));
    run_sweep("clr", 2'b11, 2'd0, 1'b0, '0);
    chk("clr_cnt_depth", inval_cnt, CW'(DEPTH));

    mem[0] = mk(1'b1, 32'd100, 2'd2, 48'h0202_0202_0202);
    mem[1] = mk(1'b0, 32'd0, 2'd2, 48'h0303_0303_0303);
    mem[2] = mk(1'b1, 32'd0, 2'd1, 48'h0404_0404_0404);
    mem[3] = mk(1'b1, 32'd0, 2'd3, 48'h0505_0505_0505);
    run_sweep("port", 2'b01, 2'd2, 1'b1, 32'd95);
    chk("port_cnt_one", inval_cnt, CW'(1));

    for (int it = 0; it < 8; it++) begin
      t = TW'($urandom_range(0, 150));
      set_time(int'(t));
      best_bfr_age = TW'($urandom_range(1, 40));
      for (int i = 0; i < DEPTH; i++)
        mem[i] = mk(1'($urandom_range(0, 1)), t - TW'($urandom_range(0, 80)), PW'($urandom),
                     {16'($urandom), 32'($urandom)});
      la = t - TW'($urandom_range(0, 80));
      age_check("rnd_idle", la, best_bfr_age, (t - la) < best_bfr_age);
      cmd = 2'($urandom_range(1, 2));
      la = t - TW'($urandom_range(0, 80));
      run_sweep("rnd", cmd, PW'($urandom), 1'($urandom_range(0, 1)), la);
    end

    for (int i = 0; i < DEPTH; i++) mem[i] = mk(1'b1, t_now, PW'(i), MW'(i + 1));
    command = 2'b11;
    tick();
    command = 2'b00;
    tick();
    p_reset = 1'b1;
    tick();
    chk("rst_mid_active", age_check_active, 1'b0);
    chk("rst_mid_wr", mem_wr, 1'b0);
    chk("rst_mid_rd", mem_rd, 1'b0);
    chk("rst_mid_cnt", inval_cnt, '0);
    p_reset = 1'b0;
    ws = wlog.size();
    repeat (6) tick();
    chk("rst_mid_no_access", wlog.size(), ws);
    chk("rst_mid_no_done", sweep_done, 1'b0);

    chk("rd_wr_exclusive", both_hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
